win_sum_decoder: RTL and testbench

Inverse of the 4-sample sliding-window summer: consumes the stream of window sums, one per accepted clock edge, and recovers the original 8-bit sample stream. It sits at the receiving end of a link that carries only window sums. It tracks the encoder's history, with the same zero-initialised pre-history, and flags any sum sequence that no valid sample stream could have produced. One sample is recovered per valid sum, with one cycle of latency.

---
 rtl/win_sum_decoder.sv | 122 ++++++++++++
 tb/tb_win_sum_decoder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/win_sum_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : win_sum_decoder
//  Description : Inverse of an N-sample sliding-window summer. Each accepted
//                window sum s[n] = x[n] + ... + x[n-N+1] is turned back into
//                the sample x[n], using the last N recovered samples and the
//                previous sum. The encoder's pre-history is taken as all-zero.
//                Any sum stream that no legal sample stream could produce sets
//                a sticky error flag and freezes the decoder until reset.
//  Ports       : clk       - rising-edge clock
//                reset     - synchronous active-high reset
//                in_valid  - in_sum carries a new window sum this cycle
//                in_sum    - incoming window sum (SW bits)
//                out       - last recovered sample (registered)
//                out_valid - one-cycle pulse, out updated at the last edge
//                err       - sticky inconsistency flag
//  Revision    : 1.0 - initial release
// ============================================================================
module win_sum_decoder #(
    parameter int W  = 8,
    parameter int N  = 4,
    parameter int SW = W + $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [SW-1:0] in_sum,
    output logic [W-1:0]  out,
    output logic          out_valid,
    output logic          err
);

    // Largest sum a legal window of N full-scale samples can produce.
    localparam logic [SW-1:0] C_MAX_SUM = SW'(N * ((1 << W) - 1));

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [W-1:0]         r_hist [N];
    logic [SW-1:0]        r_prev_sum;
    logic [W-1:0]         r_out;
    logic                 r_out_valid;
    logic                 r_err;

    logic signed [SW+1:0] w_cand;
    logic                 w_legal;
    logic                 w_accept;
    logic                 w_reject;

    // The candidate can run negative or beyond the sample range on a corrupt
    // stream, so it is carried two bits wider than the sum and range-checked
    // before any truncation to W bits.
    assign w_cand = $signed({2'b00, in_sum})
                  - $signed({2'b00, r_prev_sum})
                  + $signed({{(SW + 2 - W){1'b0}}, r_hist[N-1]});

    // In [0, 2^W-1] exactly when the sign bit and every bit above W-1 are 0.
    assign w_legal = (w_cand[SW+1:W] == '0) && (in_sum <= C_MAX_SUM);

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_reject     = 1'b0;
        case (r_state)
            ST_IDLE, ST_RUN: begin
                if (in_valid) begin
                    if (w_legal) begin
                        w_accept     = 1'b1;
                        w_state_next = ST_RUN;
                    end else begin
                        w_reject     = 1'b1;
                        w_state_next = ST_ERR;
                    end
                end
            end
            ST_ERR: begin
                w_state_next = ST_ERR;
            end
            default: begin
                w_state_next = ST_ERR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_prev_sum  <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
            for (int i = 0; i < N; i++) begin
                r_hist[i] <= '0;
            end
        end else begin
            r_state     <= w_state_next;
            r_out_valid <= w_accept;
            if (w_accept) begin
                r_out      <= w_cand[W-1:0];
                r_prev_sum <= in_sum;
                r_hist[0]  <= w_cand[W-1:0];
                for (int i = 1; i < N; i++) begin
                    r_hist[i] <= r_hist[i-1];
                end
            end
            if (w_reject) begin
                r_err <= 1'b1;
            end
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_win_sum_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_win_sum_decoder
//  Description : Self-checking bench for win_sum_decoder. Directed scenarios
//                with known answers, followed by a randomized stream checked
//                against a sample-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_win_sum_decoder;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int SW = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic [SW-1:0] in_sum = '0;
    logic [W-1:0]  out;
    logic          out_valid;
    logic          err;

    int n_cmp  = 0;
    int n_fail = 0;

    win_sum_decoder #(.W(W), .N(N), .SW(SW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_sum    (in_sum),
        .out       (out),
        .out_valid (out_valid),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Reference model: the full list of recovered samples. A window sum is the
    // new sample plus the N-1 samples before it, so x[n] = s[n] - (sum of the
    // previous N-1 recovered samples).
    int   m_x[$];
    int   m_out;
    logic m_valid;
    logic m_err;

    function automatic int prev_part();
        int acc = 0;
        for (int k = 1; k < N; k++) acc += m_x[m_x.size() - k];
        return acc;
    endfunction

    task automatic model_reset();
        m_x = {};
        for (int k = 0; k < N; k++) m_x.push_back(0);
        m_out = 0; m_valid = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_step(input logic v, input int s);
        int cand;
        m_valid = 1'b0;
        if (v && !m_err) begin
            cand = s - prev_part();
            if (s <= N * 255 && cand >= 0 && cand <= 255) begin
                m_x.push_back(cand);
                if (m_x.size() > 2 * N) void'(m_x.pop_front());
                m_out = cand; m_valid = 1'b1;
            end else begin
                m_err = 1'b1;
            end
        end
    endtask

    // One clock with the given inputs; returns #1 after the edge.
    task automatic step(input logic v, input int s, input logic r);
        reset = r; in_valid = v; in_sum = SW'(s);
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0; in_sum = '0;
    endtask

    task automatic test_reset();
        step(1'b1, 0, 1'b1);
        step(1'b0, 0, 1'b1);
        n_cmp++;
        if (out !== 8'd0) begin n_fail++; $display("FAIL reset_out actual=%0d required=0", out); end
        n_cmp++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid actual=%b required=0", out_valid); end
        n_cmp++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err actual=%b required=0", err); end
    endtask

    task automatic test_basic();
        int s[6] = '{100, 200, 200, 250, 200, 350};
        int e[6] = '{100, 100, 0, 50, 50, 250};
        step(1'b0, 0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, s[i], 1'b0);
            n_cmp++;
            if ({out_valid, err, out} !== {1'b1, 1'b0, 8'(e[i])}) begin
                n_fail++;
                $display("FAIL basic[%0d] actual v=%b e=%b out=%0d required v=1 e=0 out=%0d",
                         i, out_valid, err, out, e[i]);
            end
        end
        step(1'b0, 0, 1'b0);
        n_cmp++;
        if (out_valid !== 1'b0 || out !== 8'd250) begin
            n_fail++; $display("FAIL basic_pulse actual v=%b out=%0d required v=0 out=250", out_valid, out);
        end
    endtask

    task automatic test_saturation();
        int s[8] = '{255, 510, 765, 1020, 765, 510, 255, 0};
        int e[8] = '{255, 255, 255, 255, 0, 0, 0, 0};
        step(1'b0, 0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, s[i], 1'b0);
            n_cmp++;
            if ({out_valid, err, out} !== {1'b1, 1'b0, 8'(e[i])}) begin
                n_fail++;
                $display("FAIL saturation[%0d] actual v=%b e=%b out=%0d required v=1 e=0 out=%0d",
                         i, out_valid, err, out, e[i]);
            end
        end
    endtask

    task automatic test_gaps_reset();
        step(1'b0, 0, 1'b1);
        step(1'b1, 10, 1'b0);
        step(1'b1, 21, 1'b0);
        n_cmp++;
        if ({out_valid, out} !== {1'b1, 8'd11}) begin
            n_fail++; $display("FAIL gaps_second actual v=%b out=%0d required v=1 out=11", out_valid, out);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 77, 1'b0);
            n_cmp++;
            if ({out_valid, err, out} !== {1'b0, 1'b0, 8'd11}) begin
                n_fail++; $display("FAIL gaps_idle[%0d] actual v=%b e=%b out=%0d required v=0 e=0 out=11",
                                   i, out_valid, err, out);
            end
        end
        step(1'b1, 33, 1'b0);
        n_cmp++;
        if ({out_valid, err, out} !== {1'b1, 1'b0, 8'd12}) begin
            n_fail++; $display("FAIL gaps_after actual v=%b e=%b out=%0d required v=1 e=0 out=12", out_valid, err, out);
        end
        step(1'b1, 999, 1'b1);
        n_cmp++;
        if ({out_valid, err, out} !== {1'b0, 1'b0, 8'd0}) begin
            n_fail++; $display("FAIL gaps_reset actual v=%b e=%b out=%0d required v=0 e=0 out=0", out_valid, err, out);
        end
        step(1'b1, 20, 1'b0);
        n_cmp++;
        if ({out_valid, err, out} !== {1'b1, 1'b0, 8'd20}) begin
            n_fail++; $display("FAIL gaps_post_reset actual v=%b e=%b out=%0d required v=1 e=0 out=20", out_valid, err, out);
        end
    endtask

    task automatic test_neg_err();
        int s[4] = '{50, 150, 200, 0};
        step(1'b0, 0, 1'b1);
        step(1'b1, 100, 1'b0);
        n_cmp++;
        if ({out_valid, err, out} !== {1'b1, 1'b0, 8'd100}) begin
            n_fail++; $display("FAIL neg_first actual v=%b e=%b out=%0d required v=1 e=0 out=100", out_valid, err, out);
        end
        for (int i = 0; i < 4; i++) begin
            step(i < 3, s[i], 1'b0);
            n_cmp++;
            if ({out_valid, err, out} !== {1'b0, 1'b1, 8'd100}) begin
                n_fail++; $display("FAIL neg_err[%0d] actual v=%b e=%b out=%0d required v=0 e=1 out=100",
                                   i, out_valid, err, out);
            end
        end
        step(1'b0, 0, 1'b1);
        step(1'b1, 7, 1'b0);
        n_cmp++;
        if ({out_valid, err, out} !== {1'b1, 1'b0, 8'd7}) begin
            n_fail++; $display("FAIL neg_recover actual v=%b e=%b out=%0d required v=1 e=0 out=7", out_valid, err, out);
        end
    endtask

    task automatic test_range_err();
        step(1'b0, 0, 1'b1);
        step(1'b1, 1021, 1'b0);
        n_cmp++;
        if ({out_valid, err, out} !== {1'b0, 1'b1, 8'd0}) begin
            n_fail++; $display("FAIL range_1021 actual v=%b e=%b out=%0d required v=0 e=1 out=0", out_valid, err, out);
        end
        step(1'b1, 0, 1'b0);
        n_cmp++;
        if ({out_valid, err, out} !== {1'b0, 1'b1, 8'd0}) begin
            n_fail++; $display("FAIL range_hold actual v=%b e=%b out=%0d required v=0 e=1 out=0", out_valid, err, out);
        end
        step(1'b0, 0, 1'b1);
        step(1'b1, 255, 1'b0);
        step(1'b1, 511, 1'b0);
        n_cmp++;
        if ({out_valid, err, out} !== {1'b0, 1'b1, 8'd255}) begin
            n_fail++; $display("FAIL range_256 actual v=%b e=%b out=%0d required v=0 e=1 out=255", out_valid, err, out);
        end
        step(1'b0, 0, 1'b1);
        step(1'b1, 5, 1'b0);
        step(1'b1, 4, 1'b0);
        n_cmp++;
        if ({out_valid, err, out} !== {1'b0, 1'b1, 8'd5}) begin
            n_fail++; $display("FAIL range_minus1 actual v=%b e=%b out=%0d required v=0 e=1 out=5", out_valid, err, out);
        end
    endtask

    task automatic test_random();
        logic v;
        int   s;
        step(1'b0, 0, 1'b1);
        model_reset();
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) s = $urandom_range(0, 1023);
            else s = $urandom_range(0, 255) + prev_part();
            if ((m_err && $urandom_range(0, 7) == 0) || $urandom_range(0, 99) == 0) begin
                step(v, s, 1'b1);
                model_reset();
            end else begin
                step(v, s, 1'b0);
                model_step(v, s);
            end
            n_cmp++;
            if ({out_valid, err, out} !== {m_valid, m_err, 8'(m_out)}) begin
                n_fail++;
                $display("FAIL random[%0d] sum=%0d actual v=%b e=%b out=%0d required v=%b e=%b out=%0d",
                         i, s, out_valid, err, out, m_valid, m_err, m_out);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_saturation();
        test_gaps_reset();
        test_neg_err();
        test_range_err();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
